chunked_adder_sequencer: RTL and testbench

//   Performs W-bit add/subtract by time-multiplexing one CHUNK-bit ripple_carry_adder

---
 rtl/chunked_adder_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_chunked_adder_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder_sequencer (with helper ripple_carry_adder)
// Purpose  : W-bit add/subtract computed over W/CHUNK cycles by reusing one
//            CHUNK-bit ripple-carry adder, low chunk first, with the
//            inter-chunk carry held in a register. Valid/ready on both sides.
// Ports    : clk, rst (async, active-high)
//            i_in_valid / o_in_ready   : operand handshake (ready only in IDLE)
//            i_a, i_b, i_sub, i_cin    : operands, subtract select, carry-in
//            o_out_valid / i_out_ready : result handshake (valid only in DONE)
//            o_sum, o_cout, o_overflow : result, carry out, signed overflow
//            o_busy                    : high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// ripple_carry_adder : combinational WIDTH-bit adder; overflow is the XOR of
// the carry into and out of the top bit.
// ----------------------------------------------------------------------------
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  logic w_c;
  logic w_c_msb;

  // Carry is walked as a variable rather than a vector so the chain does not
  // form a self-referencing net.
  always_comb begin
    w_c     = i_cin;
    w_c_msb = i_cin;
    o_sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) w_c_msb = w_c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout     = w_c;
    o_overflow = w_c_msb ^ w_c;
  end

endmodule

// ----------------------------------------------------------------------------
// chunked_adder_sequencer : top level
// ----------------------------------------------------------------------------
module chunked_adder_sequencer #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  input  logic         i_cin,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int NCHUNK = W / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OFFW   = (W > 1) ? $clog2(W) : 1;

  if ((CHUNK < 1) || (CHUNK > W) || ((W % CHUNK) != 0)) begin : g_bad_chunk
    $error("chunked_adder_sequencer: CHUNK must divide W and lie in 1..W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_last;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;       // already inverted for subtract
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [OFFW-1:0]   w_off;
  logic [CHUNK-1:0]  w_chunk_sum;
  logic              w_chunk_cout;
  logic              w_chunk_ovf;

  // Bit offset of the current chunk. When CHUNK==W the constant may truncate
  // to zero in OFFW bits, which is harmless because r_idx is then always 0.
  assign w_off  = OFFW'(r_idx) * OFFW'(CHUNK);
  assign w_last = (r_idx == IDXW'(NCHUNK - 1));

  ripple_carry_adder #(
    .WIDTH (CHUNK)
  ) u_rca (
    .i_a        (r_a[w_off +: CHUNK]),
    .i_b        (r_b[w_off +: CHUNK]),
    .i_cin      (r_carry),
    .o_sum      (w_chunk_sum),
    .o_cout     (w_chunk_cout),
    .o_overflow (w_chunk_ovf)
  );

  // -------------------------------------------------------------- FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ------------------------------------------------- FSM next state / flags
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy     = 1'b0;
        // Held low while reset is asserted so all outputs read zero then.
        o_in_ready = ~rst;
        if (i_in_valid && !rst) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_sub ? ~i_b : i_b;
        r_carry <= i_sub | i_cin;      // subtract forces +1, ignores cin
        r_idx   <= '0;
      end else if (r_state == S_RUN) begin
        r_sum[w_off +: CHUNK] <= w_chunk_sum;
        r_carry               <= w_chunk_cout;
        if (w_last) begin
          r_cout <= w_chunk_cout;
          r_ovf  <= w_chunk_ovf;
          r_idx  <= '0;
        end else begin
          r_idx  <= r_idx + IDXW'(1);
        end
      end
    end
  end

  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_adder_sequencer
// Purpose  : Directed and randomized checks of chunked_adder_sequencer with
//            CHUNK = 1, 8 and 32 (W = 32) against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_adder_sequencer;

  localparam int W = 32;

  logic              clk;
  logic              rst;
  logic [2:0]        iv;
  logic [2:0]        ordy;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              sub;
  logic              cin;
  logic [2:0]        ir_o;
  logic [2:0]        ov_o;
  logic [2:0][W-1:0] sum_o;
  logic [2:0]        cout_o;
  logic [2:0]        ovf_o;
  logic [2:0]        busy_o;

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chunked_adder_sequencer #(.W(W), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .i_in_valid(iv[0]), .o_in_ready(ir_o[0]),
    .i_a(a), .i_b(b), .i_sub(sub), .i_cin(cin),
    .o_out_valid(ov_o[0]), .i_out_ready(ordy[0]), .o_sum(sum_o[0]),
    .o_cout(cout_o[0]), .o_overflow(ovf_o[0]), .o_busy(busy_o[0]));

  chunked_adder_sequencer #(.W(W), .CHUNK(8)) u_dut_c8 (
    .clk(clk), .rst(rst), .i_in_valid(iv[1]), .o_in_ready(ir_o[1]),
    .i_a(a), .i_b(b), .i_sub(sub), .i_cin(cin),
    .o_out_valid(ov_o[1]), .i_out_ready(ordy[1]), .o_sum(sum_o[1]),
    .o_cout(cout_o[1]), .o_overflow(ovf_o[1]), .o_busy(busy_o[1]));

  chunked_adder_sequencer #(.W(W), .CHUNK(32)) u_dut_c32 (
    .clk(clk), .rst(rst), .i_in_valid(iv[2]), .o_in_ready(ir_o[2]),
    .i_a(a), .i_b(b), .i_sub(sub), .i_cin(cin),
    .o_out_valid(ov_o[2]), .i_out_ready(ordy[2]), .o_sum(sum_o[2]),
    .o_cout(cout_o[2]), .o_overflow(ovf_o[2]), .o_busy(busy_o[2]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic; returns {overflow, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms, input logic mc);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         ov;
    bb = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
    ov = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
    return {ov, r};
  endfunction

  // One complete transaction on the CHUNK=8 instance with fixed expectations.
  task automatic op8(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                     input logic ts, input logic tc, input logic [W-1:0] es,
                     input logic ec, input logic eo, input logic early_rdy);
    int n;
    n = 0;
    while (!ir_o[1] && n < 100) begin tick; n++; end
    chk({tag, "_rdy"}, ir_o[1], 1);
    a = ta; b = tb_; sub = ts; cin = tc; iv[1] = 1'b1;
    tick;                                   // acceptance edge E0
    iv[1] = 1'b0;
    a = $urandom; b = $urandom; cin = ~cin; // must not disturb latched operands
    if (early_rdy) ordy[1] = 1'b1;          // no effect outside DONE
    n = 0;
    while (!ov_o[1] && n < 50) begin tick; n++; end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_sum"}, sum_o[1], es);
    chk({tag, "_cout"}, cout_o[1], ec);
    chk({tag, "_ovf"}, ovf_o[1], eo);
    ordy[1] = 1'b1;
    tick;
    ordy[1] = 1'b0;
    chk({tag, "_idle"}, {ov_o[1], ir_o[1], busy_o[1]}, 3'b010);
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [2:0]   done;
    int           n;

    rst = 1'b1; iv = '0; ordy = '0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    tick; tick;
    chk("rst_hold_outs", {sum_o[1], cout_o[1], ovf_o[1], ov_o[1], busy_o[1], ir_o[1]}, '0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", ir_o, 3'b111);
    chk("rst_release_busy", busy_o, 3'b000);

    // Spec examples on CHUNK=8
    op8("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    op8("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    op8("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op8("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    op8("add_cin",   32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b1, 32'h2222_2221, 1'b0, 1'b0, 1'b0);

    // Back-pressure in DONE: results must stay put for 10 cycles
    a = 32'h00FF_00FF; b = 32'h0001_0001; sub = 1'b0; cin = 1'b0; iv[1] = 1'b1;
    tick;
    a = '0; b = '0;                         // in_valid left high while busy
    n = 0;
    while (!ov_o[1] && n < 50) begin tick; n++; end
    for (int i = 0; i < 10; i++) begin
      chk("hold_vals", {sum_o[1], cout_o[1], ovf_o[1]}, {32'h0100_0100, 1'b0, 1'b0});
      chk("hold_flags", {ov_o[1], ir_o[1], busy_o[1]}, 3'b101);
      tick;
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    tick;
    ordy[1] = 1'b0;
    chk("hold_release", {ov_o[1], ir_o[1], busy_o[1]}, 3'b010);

    // Reset in the middle of RUN (idx==2), carry register holding 1
    a = 32'h00FF_FFFF; b = 32'h0000_0001; sub = 1'b0; cin = 1'b0; iv[1] = 1'b1;
    tick;                                   // E0
    tick; tick;                             // E1, E2 -> idx=2
    chk("mid_run_busy", busy_o[1], 1);
    rst = 1'b1;
    #1;
    chk("mid_run_rst", {sum_o[1], cout_o[1], ovf_o[1], ov_o[1], busy_o[1]}, '0);
    tick;
    rst = 1'b0;
    iv[1] = 1'b0;
    op8("post_rst", 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0, 32'h0200_0000, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, all three chunk widths in lock-step acceptance
    for (int t = 0; t < 40; t++) begin
      n = 0;
      while (ir_o != 3'b111 && n < 200) begin tick; n++; end
      chk("rnd_idle", ir_o, 3'b111);
      repeat ($urandom_range(0, 3)) tick;
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      if (t % 10 == 0) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
      if (t % 10 == 5) begin a = 32'h8000_0000; b = 32'h8000_0000; end
      exp = model(a, b, sub, cin);
      iv = 3'b111;
      tick;
      iv = 3'b000;
      chk("rnd_busy", busy_o, 3'b111);
      a = ~a; b = ~b; sub = ~sub;
      done = '0;
      n = 0;
      while (done != 3'b111 && n < 300) begin
        for (int k = 0; k < 3; k++) begin
          if (!done[k]) begin
            ordy[k] = 1'($urandom_range(0, 1));
            if (ov_o[k] && ordy[k]) begin
              chk($sformatf("rnd_sum_k%0d", k), sum_o[k], exp[W-1:0]);
              chk($sformatf("rnd_cout_k%0d", k), cout_o[k], exp[W]);
              chk($sformatf("rnd_ovf_k%0d", k), ovf_o[k], exp[W+1]);
              done[k] = 1'b1;
            end
          end else begin
            ordy[k] = 1'b0;
          end
        end
        tick;
        n++;
      end
      ordy = '0;
      chk("rnd_done", done, 3'b111);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
